mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- Memory stage directly downstream of the ALU stage in the multicycle MIPS datapath.
- Takes ALU_out as the effective byte address and RF_B as store data.
- Runs a req/ack transaction to a variable-latency data memory, with word and byte access.
- Returns a registered load result and a one-cycle completion pulse to the control FSM.

Parameters:
- TIMEOUT_CYC, 255, max cycles in WAIT before abort (used only with MEM_TIMEOUT_EN).

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- Mem_start  in  1  one-cycle pulse, begin access; sampled only in IDLE.
- Mem_wr  in  1  1 = store, 0 = load; latched at start.
- Byte_op  in  1  1 = byte access (sb/lb), 0 = word (sw/lw); latched at start.
- ALU_out  in  32  effective byte address; latched at start.
- RF_B  in  32  store data; latched at start.
- Dmem_req  out  1  request to data memory, held until ack.
- Dmem_we  out  1  write enable, valid while Dmem_req.
- Dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- Dmem_be  out  4  byte enables, little-endian lane = addr[1:0].
- Dmem_wdata  out  32  store data, replicated to all lanes for byte stores.
- Dmem_rdata  in  32  read data, valid with Dmem_ack.
- Dmem_ack  in  1  one-cycle completion from memory.
- MEM_out  out  32  registered load result.
- Mem_done  out  1  one-cycle pulse, access complete.
- Mem_busy  out  1  high in any state other than IDLE.
- Addr_err  out  1  one-cycle pulse, misaligned word access.

Behaviour:
- Reset: state=IDLE; Dmem_req, Dmem_we, Mem_done, Mem_busy, Addr_err = 0; Dmem_addr, Dmem_be, Dmem_wdata, MEM_out = 0.
- Reset mid-access drops Dmem_req at the next edge; a later ack is ignored.
- States: IDLE, WAIT, DONE, ERR. All outputs are registered.
- IDLE, Mem_start=1:
  - Latch op, address and data.
  - If !Byte_op and addr[1:0]!=0: go to ERR, no memory request.
  - Otherwise go to WAIT with Dmem_req=1.
- WAIT: hold Dmem_req and all Dmem_* outputs stable. On Dmem_ack:
  - Load: capture the aligned result into MEM_out.
  - Deassert req and go to DONE.
- DONE: Mem_done=1 for one cycle, then IDLE.
- ERR: Addr_err=1 for one cycle, then IDLE. MEM_out unchanged.
- Latency: start at cycle 0; req high from cycle 1; ack at cycle k>=1; Mem_done at cycle k+1.
  - Minimum start-to-done is 2 cycles (ack in cycle 1).
- Byte enables: word = 4'b1111; byte = 4'b0001 << addr[1:0].
- Byte load: MEM_out = zero-extended lane addr[1:0] of Dmem_rdata. Word load: MEM_out = Dmem_rdata.
- Stores do not modify MEM_out. MEM_out holds until the next completed load.
- Ignored inputs:
  - Mem_start when not in IDLE, including in the DONE cycle.
  - Dmem_ack outside WAIT.
- A new Mem_start is accepted in the cycle after Mem_done is seen, i.e. when back in IDLE.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With the macro:
  - An 8+ bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYC without ack: drop req, go to ERR, pulse Addr_err. MEM_out unchanged.
  - Ack and timeout in the same cycle: ack wins.
- Without the macro: no counter; WAIT persists until ack.

Decomposition:
- Package mips_mem_pkg holds:
  - state enum (IDLE, WAIT, DONE, ERR);
  - BE_WORD = 4'b1111 and BE_BYTE0 = 4'b0001;
  - DEFAULT_TIMEOUT = 255.
- Sub-module mem_load_align is combinational: rdata, addr[1:0], Byte_op -> aligned 32-bit load value. It is instantiated once.

Test Plan:
- Word load: start with ALU_out=0x100, Mem_wr=0, Byte_op=0; ack at cycle 3 with rdata=0xDEADBEEF -> Dmem_addr=0x100, be=1111, we=0, MEM_out=0xDEADBEEF, Mem_done at cycle 4.
- Byte store: ALU_out=0x203, RF_B=0x000000A5, Byte_op=1, Mem_wr=1 -> Dmem_addr=0x200, be=1000, wdata=0xA5A5A5A5, we=1; MEM_out unchanged.
- Byte load, lane 2: ALU_out=0x42, rdata=0x11223344 -> MEM_out=0x00000022.
- Misaligned word: ALU_out=0x102, Byte_op=0 -> Dmem_req never asserts, Addr_err pulses at cycle 1, Mem_done stays 0.
- Ignored inputs: Mem_start pulsed during WAIT, plus a spurious ack in IDLE -> no second transaction, state and MEM_out unaffected. Reset during WAIT -> Dmem_req=0 next cycle, then a clean new access completes.
- MEM_TIMEOUT_EN with TIMEOUT_CYC=4 and no ack -> req drops and Addr_err pulses after 4 WAIT cycles. Ack arriving in the timeout cycle -> normal Mem_done.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS memory stage.
//   mem_state_t     : memory-stage FSM states
//   BE_WORD/BE_BYTE0: byte-enable patterns (word, byte lane 0)
//   DEFAULT_TIMEOUT : default WAIT abort limit when MEM_TIMEOUT_EN is defined
package mips_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } mem_state_t;

   localparam logic [3:0] BE_WORD  = 4'b1111;
   localparam logic [3:0] BE_BYTE0 = 4'b0001;

   localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_load_align.sv
// Combinational load aligner.
//   rdata   in  32  raw word from data memory
//   lane    in  2   byte lane (addr[1:0])
//   byte_op in  1   1 = byte load (zero-extended), 0 = word load
//   aligned out 32  value to be written to MEM_out
module mem_load_align (
   input  logic [31:0] rdata,
   input  logic [1:0]  lane,
   input  logic        byte_op,
   output logic [31:0] aligned
);

   logic [7:0] lane_byte;

   always_comb begin
      lane_byte = rdata[7:0];
      case (lane)
         2'd0: lane_byte = rdata[7:0];
         2'd1: lane_byte = rdata[15:8];
         2'd2: lane_byte = rdata[23:16];
         2'd3: lane_byte = rdata[31:24];
         default: lane_byte = rdata[7:0];
      endcase
   end

   assign aligned = byte_op ? {24'd0, lane_byte} : rdata;

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory stage controller: runs one req/ack transaction to a variable-latency
// data memory per Mem_start, word or byte, load or store.
// Optional build macro: MEM_TIMEOUT_EN (abort WAIT after TIMEOUT_CYC cycles).
//
// Ports:
//   Clk, Reset (sync, active high)
//   Mem_start, Mem_wr, Byte_op, ALU_out, RF_B : request from datapath/control
//   Dmem_req/we/addr/be/wdata, Dmem_rdata, Dmem_ack : data-memory handshake
//   MEM_out  : registered load result
//   Mem_done : one-cycle completion pulse
//   Mem_busy : high whenever not IDLE
//   Addr_err : one-cycle pulse on misaligned word access (or timeout)
//
// state | meaning
// IDLE  | waiting for Mem_start
// WAIT  | Dmem_req held, waiting for Dmem_ack
// DONE  | Mem_done pulse, access complete
// ERR   | Addr_err pulse, access aborted
module mem_stage_ctrl
   import mips_mem_pkg::*;
#(
   parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Mem_start,
   input  logic        Mem_wr,
   input  logic        Byte_op,
   input  logic [31:0] ALU_out,
   input  logic [31:0] RF_B,
   output logic        Dmem_req,
   output logic        Dmem_we,
   output logic [31:0] Dmem_addr,
   output logic [3:0]  Dmem_be,
   output logic [31:0] Dmem_wdata,
   input  logic [31:0] Dmem_rdata,
   input  logic        Dmem_ack,
   output logic [31:0] MEM_out,
   output logic        Mem_done,
   output logic        Mem_busy,
   output logic        Addr_err
);

   mem_state_t  state, state_nx;
   logic        req_nx, we_nx, done_nx, busy_nx, err_nx;
   logic [31:0] addr_nx, wdata_nx, out_nx;
   logic [3:0]  be_nx;
   logic [1:0]  lane_q, lane_nx;
   logic        byte_q, byte_nx;
   logic [31:0] load_val;
   logic        timed_out;

   mem_load_align u_align (
      .rdata   (Dmem_rdata),
      .lane    (lane_q),
      .byte_op (byte_q),
      .aligned (load_val)
   );

   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be at least 1");
   end

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) < 8) ? 8 : $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] cnt_q, cnt_nx;

   // cnt_q counts completed WAIT cycles before this one, so the abort fires
   // in the TIMEOUT_CYC-th WAIT cycle.
   assign timed_out = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   always_comb begin
      cnt_nx = cnt_q;
      if (state == WAIT) cnt_nx = cnt_q + 1'b1;
      else               cnt_nx = '0;
   end

   always_ff @(posedge Clk) begin
      if (Reset) cnt_q <= '0;
      else       cnt_q <= cnt_nx;
   end
`else
   assign timed_out = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      req_nx   = Dmem_req;
      we_nx    = Dmem_we;
      addr_nx  = Dmem_addr;
      be_nx    = Dmem_be;
      wdata_nx = Dmem_wdata;
      out_nx   = MEM_out;
      done_nx  = 1'b0;
      err_nx   = 1'b0;
      busy_nx  = Mem_busy;
      lane_nx  = lane_q;
      byte_nx  = byte_q;
      case (state)
         IDLE: begin
            if (Mem_start) begin
               lane_nx  = ALU_out[1:0];
               byte_nx  = Byte_op;
               addr_nx  = {ALU_out[31:2], 2'b00};
               be_nx    = Byte_op ? (BE_BYTE0 << ALU_out[1:0]) : BE_WORD;
               wdata_nx = Byte_op ? {4{RF_B[7:0]}} : RF_B;
               busy_nx  = 1'b1;
               if (!Byte_op && (ALU_out[1:0] != 2'b00)) begin
                  state_nx = ERR;
                  err_nx   = 1'b1;
               end else begin
                  state_nx = WAIT;
                  req_nx   = 1'b1;
                  we_nx    = Mem_wr;
               end
            end
         end
         WAIT: begin
            if (Dmem_ack) begin
               if (!Dmem_we) out_nx = load_val;
               state_nx = DONE;
               req_nx   = 1'b0;
               we_nx    = 1'b0;
               done_nx  = 1'b1;
            end else if (timed_out) begin
               state_nx = ERR;
               req_nx   = 1'b0;
               we_nx    = 1'b0;
               err_nx   = 1'b1;
            end
         end
         DONE: begin
            state_nx = IDLE;
            busy_nx  = 1'b0;
         end
         ERR: begin
            state_nx = IDLE;
            busy_nx  = 1'b0;
         end
         default: begin
            state_nx = IDLE;
            busy_nx  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= IDLE;
         Dmem_req   <= 1'b0;
         Dmem_we    <= 1'b0;
         Dmem_addr  <= '0;
         Dmem_be    <= '0;
         Dmem_wdata <= '0;
         MEM_out    <= '0;
         Mem_done   <= 1'b0;
         Mem_busy   <= 1'b0;
         Addr_err   <= 1'b0;
         lane_q     <= '0;
         byte_q     <= 1'b0;
      end else begin
         state      <= state_nx;
         Dmem_req   <= req_nx;
         Dmem_we    <= we_nx;
         Dmem_addr  <= addr_nx;
         Dmem_be    <= be_nx;
         Dmem_wdata <= wdata_nx;
         MEM_out    <= out_nx;
         Mem_done   <= done_nx;
         Mem_busy   <= busy_nx;
         Addr_err   <= err_nx;
         lane_q     <= lane_nx;
         byte_q     <= byte_nx;
      end
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed cases then random
// transactions against a transaction-level reference model.
module tb_mem_stage_ctrl;

`ifdef MEM_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, wr = 1'b0, bop = 1'b0;
   logic [31:0] alu = '0, rfb = '0, rdata = '0;
   logic        ack = 1'b0;
   logic        req, we, done, busy, aerr;
   logic [31:0] daddr, wdata, mout;
   logic [3:0]  be;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_out = '0;

   always #5 clk = ~clk;

   mem_stage_ctrl #(.TIMEOUT_CYC(TO > 0 ? TO : 255)) dut (
      .Clk(clk), .Reset(rst), .Mem_start(start), .Mem_wr(wr), .Byte_op(bop),
      .ALU_out(alu), .RF_B(rfb), .Dmem_req(req), .Dmem_we(we), .Dmem_addr(daddr),
      .Dmem_be(be), .Dmem_wdata(wdata), .Dmem_rdata(rdata), .Dmem_ack(ack),
      .MEM_out(mout), .Mem_done(done), .Mem_busy(busy), .Addr_err(aerr)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
      total++;
      if (got !== expv) begin
         bad++;
         $display("FAIL %s got=%h expected=%h", tag, got, expv);
      end
   endtask

   // k = cycle in which ack arrives (>=1); k = 0 means never ack.
   // poke = pulse Mem_start with other fields during WAIT.
   task automatic do_txn(input logic t_wr, input logic t_bop, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rd, input int k,
                         input logic poke);
      int lane;
      logic [31:0] e_addr, e_wdata, e_load;
      logic [3:0]  e_be;
      lane    = int'(a % 4);
      e_addr  = a - 32'(lane);
      e_be    = t_bop ? 4'(1 << lane) : 4'hF;
      e_wdata = t_bop ? (d & 32'hFF) * 32'h01010101 : d;
      e_load  = t_bop ? ((rd >> (8 * lane)) & 32'hFF) : rd;

      @(negedge clk);
      start = 1'b1; wr = t_wr; bop = t_bop; alu = a; rfb = d;
      @(negedge clk);
      start = 1'b0; alu = $urandom; rfb = $urandom; wr = $urandom; bop = $urandom;

      if (!t_bop && lane != 0) begin
         chk("misalign_err", 32'(aerr), 1);
         chk("misalign_noreq", 32'(req), 0);
         chk("misalign_nodone", 32'(done), 0);
         @(negedge clk);
         chk("misalign_err_clr", 32'(aerr), 0);
         chk("misalign_busy_clr", 32'(busy), 0);
         chk("misalign_out", mout, exp_out);
         return;
      end

      for (int c = 1; c <= 64; c++) begin
         chk("wait_req", 32'(req), 1);
         chk("wait_addr", daddr, e_addr);
         chk("wait_be", 32'(be), 32'(e_be));
         chk("wait_we", 32'(we), 32'(t_wr));
         chk("wait_wdata", wdata, e_wdata);
         chk("wait_busy", 32'(busy), 1);
         if (poke && c == 1) begin
            start = 1'b1; alu = 32'h0000_0FF1; bop = 1'b0;
            @(negedge clk);
            start = 1'b0;
            if (k == 1) begin
               chk("poke_k1", 32'(k), 2);
               return;
            end
            continue;
         end
         if (c == k) begin
            ack = 1'b1; rdata = rd;
            @(negedge clk);
            ack = 1'b0; rdata = $urandom;
            if (!t_wr) exp_out = e_load;
            chk("done_pulse", 32'(done), 1);
            chk("done_busy", 32'(busy), 1);
            chk("done_noreq", 32'(req), 0);
            chk("done_noerr", 32'(aerr), 0);
            chk("done_out", mout, exp_out);
            @(negedge clk);
            chk("done_clr", 32'(done), 0);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_out", mout, exp_out);
            return;
         end
         if (TO > 0 && c == TO) begin
            @(negedge clk);
            chk("to_err", 32'(aerr), 1);
            chk("to_noreq", 32'(req), 0);
            chk("to_nodone", 32'(done), 0);
            chk("to_out", mout, exp_out);
            @(negedge clk);
            chk("to_err_clr", 32'(aerr), 0);
            chk("to_busy_clr", 32'(busy), 0);
            return;
         end
         @(negedge clk);
      end
      chk("txn_budget", 0, 1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_req", 32'(req), 0);
      chk("rst_we", 32'(we), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err", 32'(aerr), 0);
      chk("rst_addr", daddr, 0);
      chk("rst_be", 32'(be), 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_out", mout, 0);
      rst = 1'b0;

      // Directed cases.
      do_txn(1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 3, 1'b0);
      do_txn(1'b1, 1'b1, 32'h203, 32'hA5, 32'h12345678, 2, 1'b0);
      chk("store_keeps_out", mout, 32'hDEADBEEF);
      do_txn(1'b0, 1'b1, 32'h42, 32'h0, 32'h11223344, 1, 1'b0);
      chk("lb_lane2", mout, 32'h22);
      do_txn(1'b0, 1'b0, 32'h102, 32'h0, 32'h0, 1, 1'b0);
      do_txn(1'b0, 1'b0, 32'h300, 32'h0, 32'hCAFEF00D, 4, 1'b1);

      // Spurious ack in IDLE.
      @(negedge clk);
      ack = 1'b1; rdata = 32'h5555AAAA;
      @(negedge clk);
      ack = 1'b0;
      chk("spur_busy", 32'(busy), 0);
      chk("spur_done", 32'(done), 0);
      chk("spur_req", 32'(req), 0);
      @(negedge clk);
      chk("spur_out", mout, exp_out);

      // Reset during WAIT, late ack ignored, then a clean access.
      start = 1'b1; wr = 1'b0; bop = 1'b0; alu = 32'h400;
      @(negedge clk);
      start = 1'b0;
      chk("rw_req", 32'(req), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rw_req_drop", 32'(req), 0);
      chk("rw_busy", 32'(busy), 0);
      exp_out = '0;
      chk("rw_out_rst", mout, exp_out);
      ack = 1'b1; rdata = 32'h77777777;
      @(negedge clk);
      ack = 1'b0;
      chk("rw_late_ack_done", 32'(done), 0);
      chk("rw_late_ack_out", mout, exp_out);
      do_txn(1'b0, 1'b0, 32'h404, 32'h0, 32'h0BADF00D, 2, 1'b0);

      if (TO > 0) begin
         do_txn(1'b0, 1'b0, 32'h500, 32'h0, 32'h1, 0, 1'b0);
         do_txn(1'b0, 1'b0, 32'h504, 32'h0, 32'h87654321, TO, 1'b0);
      end

      // Random transactions.
      for (int n = 0; n < 40; n++) begin
         logic r_wr, r_bop, r_poke;
         logic [31:0] r_a;
         int r_k;
         r_wr   = 1'($urandom);
         r_bop  = 1'($urandom);
         r_a    = $urandom;
         if (!r_bop && $urandom_range(0, 3) != 0) r_a[1:0] = 2'b00;
         r_k    = $urandom_range(1, (TO > 0) ? TO + 2 : 6);
         r_poke = ($urandom_range(0, 4) == 0) && (r_k > 1);
         do_txn(r_wr, r_bop, r_a, $urandom, $urandom, r_k, r_poke);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running expected=finished");
      $fatal(1, "time limit");
   end

endmodule
